// File: rtl/way_age_tracker.sv
// ---------------------------------------------------------------------------
// way_age_tracker
//
// Per-set, per-way age (RRPV-style) storage for the cache replacement path.
// A lookup returns the flattened age vector and way-valid mask of one set to
// the max-age selector stage one cycle after it is accepted. Updates (hit,
// fill, invalidate, age-set) are applied at their accept edge. A global decay
// sweep walks every set, one per cycle, and decrements non-zero valid ages.
//
// Ports:
//   clk_in, reset_in              clock, synchronous active-high reset
//   lookup_valid_in/_set_in       read request and set index
//   lookup_ready_out              read accepted when valid & ready
//   ages_valid_out                one-cycle pulse, read data valid
//   ages_set_out                  set index of returned data
//   way_flatted_out               ages, way i at [i*W +: W]
//   condition_out                 way-valid mask of returned set
//   update_valid_in/_type_in      update request, 00 hit 01 fill 10 inval 11 age-set
//   update_set_in/_way_in         update target (way ignored for age-set)
//   update_ready_out              update accepted when valid & ready
//   sweep_start_in                single-cycle pulse starting a decay sweep
//   busy_out                      sweep in progress
// ---------------------------------------------------------------------------
module way_age_tracker #(
    parameter int NUM_WAY                  = 16,
    parameter int NUM_SET                  = 16,
    parameter int SET_PTR_WIDTH_IN_BITS    = $clog2(NUM_SET),
    parameter int WAY_PTR_WIDTH_IN_BITS    = $clog2(NUM_WAY) + 1,
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int INSERT_AGE               = (2 ** SINGLE_WAY_WIDTH_IN_BITS) - 2
) (
    input  logic                                         clk_in,
    input  logic                                         reset_in,
    input  logic                                         lookup_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             lookup_set_in,
    output logic                                         lookup_ready_out,
    output logic                                         ages_valid_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]             ages_set_out,
    output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_flatted_out,
    output logic [NUM_WAY-1:0]                           condition_out,
    input  logic                                         update_valid_in,
    input  logic [1:0]                                   update_type_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             update_set_in,
    input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]             update_way_in,
    output logic                                         update_ready_out,
    input  logic                                         sweep_start_in,
    output logic                                         busy_out
);

    localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
    localparam logic [W-1:0] MAX_AGE    = '1;
    localparam logic [W-1:0] INSERT_VAL = W'(INSERT_AGE);

    localparam logic [1:0] OP_HIT   = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_AGE   = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                           state_reg, state_next;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] sweep_cnt_reg, sweep_cnt_next;

    // Storage: one packed age word and one valid mask per set.
    logic [W*NUM_WAY-1:0] age_reg   [NUM_SET];
    logic [NUM_WAY-1:0]   valid_reg [NUM_SET];

    // Lookup accepted last cycle; the read happens one edge later so the
    // returned data reflects storage after the accept edge's writes.
    logic                             lookup_pend_reg;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] lookup_set_pend_reg;

    logic update_accept;
    logic lookup_accept;

    assign busy_out         = (state_reg == SWEEP);
    assign update_ready_out = !busy_out;
    // An update always wins the single storage port, even to another set.
    assign lookup_ready_out = !busy_out && !update_valid_in;
    assign update_accept    = update_valid_in && update_ready_out;
    assign lookup_accept    = lookup_valid_in && lookup_ready_out;

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg     <= IDLE;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (sweep_start_in) begin
                    state_next     = SWEEP;
                    sweep_cnt_next = '0;
                end
            end
            SWEEP: begin
                if (sweep_cnt_reg == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1)) begin
                    state_next     = IDLE;
                    sweep_cnt_next = '0;
                end else begin
                    sweep_cnt_next = sweep_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next     = IDLE;
                sweep_cnt_next = '0;
            end
        endcase
    end

    // ---------------- storage ----------------
    // Sweep and updates never overlap: updates are refused while busy.
    // Every write that clears a valid bit also zeroes the age, so invalid
    // ways always read back as age 0.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int s = 0; s < NUM_SET; s++) begin
                age_reg[s]   <= '0;
                valid_reg[s] <= '0;
            end
        end else if (busy_out) begin
            for (int w = 0; w < NUM_WAY; w++) begin
                if (valid_reg[sweep_cnt_reg][w] &&
                    (age_reg[sweep_cnt_reg][w*W +: W] != '0)) begin
                    age_reg[sweep_cnt_reg][w*W +: W] <=
                        age_reg[sweep_cnt_reg][w*W +: W] - 1'b1;
                end
            end
        end else if (update_accept) begin
            for (int w = 0; w < NUM_WAY; w++) begin
                // Way indices >= NUM_WAY match no loop slot and are dropped.
                if (update_way_in == WAY_PTR_WIDTH_IN_BITS'(w)) begin
                    case (update_type_in)
                        OP_HIT: begin
                            if (valid_reg[update_set_in][w]) begin
                                age_reg[update_set_in][w*W +: W] <= '0;
                            end
                        end
                        OP_FILL: begin
                            age_reg[update_set_in][w*W +: W] <= INSERT_VAL;
                            valid_reg[update_set_in][w]      <= 1'b1;
                        end
                        OP_INVAL: begin
                            age_reg[update_set_in][w*W +: W] <= '0;
                            valid_reg[update_set_in][w]      <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                // Age-set touches every valid way and saturates at MAX_AGE.
                if ((update_type_in == OP_AGE) && valid_reg[update_set_in][w] &&
                    (age_reg[update_set_in][w*W +: W] != MAX_AGE)) begin
                    age_reg[update_set_in][w*W +: W] <=
                        age_reg[update_set_in][w*W +: W] + 1'b1;
                end
            end
        end
    end

    // ---------------- lookup read path ----------------
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            lookup_pend_reg     <= 1'b0;
            lookup_set_pend_reg <= '0;
            ages_valid_out      <= 1'b0;
            ages_set_out        <= '0;
            way_flatted_out     <= '0;
            condition_out       <= '0;
        end else begin
            lookup_pend_reg <= lookup_accept;
            if (lookup_accept) begin
                lookup_set_pend_reg <= lookup_set_in;
            end
            ages_valid_out <= lookup_pend_reg;
            // Data outputs hold their last value between results.
            if (lookup_pend_reg) begin
                ages_set_out    <= lookup_set_pend_reg;
                way_flatted_out <= age_reg[lookup_set_pend_reg];
                condition_out   <= valid_reg[lookup_set_pend_reg];
            end
        end
    end

endmodule

// File: doc/way_age_tracker.md
Name: way_age_tracker

Overview:
- Per-set, per-way age (RRPV-style) storage for the cache replacement path.
- Supplies the flattened age vector and way-valid mask of one set to the max-age selector stage, which uses them to pick the eviction candidate.
- Applies hit, fill, invalidate, per-set aging and a global decay sweep.
- All storage is in flops; one clock domain.

Parameters:
- NUM_WAY, 16, ways per set; power of two, at most 16.
- NUM_SET, 16, sets tracked; power of two, at least 2.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), set index width.
- WAY_PTR_WIDTH_IN_BITS, $clog2(NUM_WAY) + 1, way index width.
- SINGLE_WAY_WIDTH_IN_BITS, 4, age width per way; MAX_AGE = 2^W - 1.
- INSERT_AGE, 2^SINGLE_WAY_WIDTH_IN_BITS - 2, age written on fill.

Ports:
- clk_in  input  1  clock.
- reset_in  input  1  synchronous active-high reset.
- lookup_valid_in  input  1  read request.
- lookup_set_in  input  SET_PTR_WIDTH_IN_BITS  set to read.
- lookup_ready_out  output  1  lookup accepted when valid&ready.
- ages_valid_out  output  1  read data valid (one-cycle pulse).
- ages_set_out  output  SET_PTR_WIDTH_IN_BITS  set of returned data.
- way_flatted_out  output  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY  ages; way i at [i*W +: W].
- condition_out  output  NUM_WAY  way-valid mask of returned set.
- update_valid_in  input  1  update request.
- update_type_in  input  2  00 hit, 01 fill, 10 invalidate, 11 age-set.
- update_set_in  input  SET_PTR_WIDTH_IN_BITS  target set.
- update_way_in  input  WAY_PTR_WIDTH_IN_BITS  target way; ignored for 11.
- update_ready_out  output  1  update accepted when valid&ready.
- sweep_start_in  input  1  start global decay sweep (single-cycle pulse).
- busy_out  output  1  sweep in progress.

Behaviour:
- Reset (reset_in high at a clock edge): all ages 0, all valid bits 0, FSM IDLE, sweep counter 0.
  - All outputs 0, except lookup_ready_out and update_ready_out, which are 1 in the first cycle after reset.
  - Reset mid-sweep aborts the sweep immediately.
- FSM states:
  - IDLE: sweep_start_in high moves to SWEEP with counter = 0. The start is ignored in SWEEP.
  - SWEEP: one set per cycle (set = counter). Every valid way with age > 0 is decremented by 1; invalid ways are untouched. The counter increments each cycle. After processing set NUM_SET-1, go to IDLE.
  - busy_out = (state == SWEEP). A full sweep takes NUM_SET cycles.
- Ready rules:
  - update_ready_out = !busy_out.
  - lookup_ready_out = !busy_out && !update_valid_in. An update wins a same-cycle conflict, even to a different set.
  - sweep_start_in coincident with an accepted update: the update is applied in that cycle and the sweep begins next cycle.
- Update operations (applied at the accept edge):
  - hit (00): age[set][way] = 0; the valid bit is unchanged. A hit to an invalid way is ignored.
  - fill (01): age = INSERT_AGE, valid = 1.
  - invalidate (10): valid = 0, age = 0.
  - age-set (11): every valid way in the set does age = min(age+1, MAX_AGE). Saturating, no wrap.
  - update_way_in >= NUM_WAY: the operation is dropped for types 00/01/10.
- Lookup latency is 1 cycle:
  - The request is accepted at edge N. At edge N+1, ages_valid_out = 1 with ages_set_out, way_flatted_out and condition_out registered from the storage state after edge N's writes.
  - ages_valid_out deasserts the next cycle if no new lookup was accepted. Data outputs hold their last value.
  - Back-to-back lookups give one result per cycle.
- Invalid ways always read as age 0 in way_flatted_out (storage invariant), so the downstream selector sees 0 with condition 0.
- No backpressure on the output side; the consumer must sample when ages_valid_out = 1.

Test Plan:
- Reset, then lookup set 3 -> next cycle ages_valid_out=1, ages_set_out=3, way_flatted_out=0, condition_out=0.
- Fill set 5 way 7, then lookup set 5 -> way 7 field = 14 (W=4), condition_out = 16'h0080, all other fields 0.
- Fill set 2 way 0, then three age-set ops to set 2, then lookup -> way 0 = 15 (saturated, no wrap to 0). A hit to way 0 followed by lookup -> 0.
- Same-cycle update (fill set 1 way 1) and lookup of set 1 -> lookup_ready_out=0 that cycle. Lookup retried next cycle returns way 1 = 14, condition bit 1 set.
- Fill set 0 way 3 and set 15 way 3, pulse sweep_start_in -> busy_out high exactly 16 cycles, both readies 0 during it. Lookups afterwards return 13 for both sets.
- Start sweep, assert reset_in at sweep cycle 4 -> busy_out=0 and all storage cleared next cycle. A lookup of any set returns zeros.
